// File: rtl/event_seq_pkg.sv
// Shared types and helpers for the named-event trigger sequencer.
package event_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GAP      = 3'd1,
    FIRE     = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4
  } evt_seq_state_e;

  // Width of an event index; a single event line still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : event_seq_pkg

// File: rtl/evt_gap_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module evt_gap_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule : evt_gap_timer

// File: rtl/event_trigger_seq.sv
// Round-robin named-event trigger sequencer (transmitter side of the event handshake).
// Optional feature: define EVT_TIMEOUT_EN to abort a sequence when the listener does not
// acknowledge a strobe within TIMEOUT cycles (sticky timeout_o).
module event_trigger_seq
  import event_seq_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 3,
  parameter int unsigned GAP_W      = 8,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_i,
  input  logic [CNT_W-1:0]                     count_i,
  input  logic [GAP_W-1:0]                     gap_i,
  input  logic                                 ack_i,
  output logic [NUM_EVENTS-1:0]                evt_o,
  output logic [idx_width(NUM_EVENTS)-1:0]     evt_idx_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 timeout_o
);

  localparam int unsigned IW = idx_width(NUM_EVENTS);

  // Reject unusable configurations at elaboration.
  if (NUM_EVENTS < 1) begin : g_bad_num_events
    $error("event_trigger_seq: NUM_EVENTS must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("event_trigger_seq: TIMEOUT must be >= 1");
  end

  evt_seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic [GAP_W-1:0]        gap_lat_q, gap_lat_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_EVENTS-1:0]   evt_q, evt_d;
  logic [IW-1:0]           evt_idx_q, evt_idx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;

  logic                    gap_load_c;
  logic [GAP_W-1:0]        gap_val_c;
  logic                    gap_dec_c;
  logic                    gap_zero_c;
  logic                    wait_expired_c;

  // Inter-strobe gap counter.
  assign gap_dec_c = (state_q == GAP);

  evt_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (gap_load_c),
    .value_i (gap_val_c),
    .dec_i   (gap_dec_c),
    .zero_c  (gap_zero_c)
  );

`ifdef EVT_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic wait_load_c;
  logic wait_dec_c;
  logic wait_zero_c;

  // Ack wait counter: armed when leaving FIRE unacknowledged, runs TIMEOUT WAIT_ACK cycles.
  assign wait_load_c = (state_q == FIRE) && !ack_i;
  assign wait_dec_c  = (state_q == WAIT_ACK);

  evt_gap_timer #(.W(TW)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (wait_load_c),
    .value_i (TW'(TIMEOUT - 1)),
    .dec_i   (wait_dec_c),
    .zero_c  (wait_zero_c)
  );

  assign wait_expired_c = (state_q == WAIT_ACK) && wait_zero_c;
`else
  assign wait_expired_c = 1'b0;
`endif

  // Next-state and registered-output logic; outputs track the state being entered.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_lat_d   = gap_lat_q;
    idx_d       = idx_q;
    evt_d       = '0;
    evt_idx_d   = evt_idx_q;
    timeout_d   = timeout_q;
    gap_load_c  = 1'b0;
    gap_val_c   = gap_lat_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_i != '0) begin
            remaining_d = count_i;
            gap_lat_d   = gap_i;
            idx_d       = '0;
            timeout_d   = 1'b0;
            gap_load_c  = 1'b1;
            gap_val_c   = gap_i;
            state_d     = GAP;
          end else begin
            state_d = DONE;
          end
        end
      end

      GAP: begin
        if (gap_zero_c) begin
          evt_d     = NUM_EVENTS'(1) << idx_q;
          evt_idx_d = idx_q;
          state_d   = FIRE;
        end
      end

      FIRE, WAIT_ACK: begin
        if (ack_i) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            idx_d      = (idx_q == IW'(NUM_EVENTS - 1)) ? '0 : idx_q + IW'(1);
            gap_load_c = 1'b1;
            gap_val_c  = gap_lat_q;
            state_d    = GAP;
          end
        end else if (wait_expired_c) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = WAIT_ACK;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == GAP) || (state_d == FIRE) || (state_d == WAIT_ACK);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      gap_lat_q   <= '0;
      idx_q       <= '0;
      evt_q       <= '0;
      evt_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_lat_q   <= gap_lat_d;
      idx_q       <= idx_d;
      evt_q       <= evt_d;
      evt_idx_q   <= evt_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign evt_o     = evt_q;
  assign evt_idx_o = evt_idx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign timeout_o = timeout_q;

endmodule : event_trigger_seq

// File: tb/tb_event_trigger_seq.sv
// Scoreboard bench for event_trigger_seq: a timing model predicts every strobe/done pulse,
// a listener process acknowledges strobes, and a monitor pops and compares outputs.
module tb_event_trigger_seq;

  localparam int unsigned N     = 3;
  localparam int unsigned IW    = 2;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMO   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i;
  logic [CNT_W-1:0] count_i;
  logic [GAP_W-1:0] gap_i;
  logic             ack_i;
  logic [N-1:0]     evt_o;
  logic [IW-1:0]    evt_idx_o;
  logic             busy_o;
  logic             done_o;
  logic             timeout_o;

  event_trigger_seq #(
    .NUM_EVENTS (N),
    .GAP_W      (GAP_W),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .count_i   (count_i),
    .gap_i     (gap_i),
    .ack_i     (ack_i),
    .evt_o     (evt_o),
    .evt_idx_o (evt_idx_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] evt;
    logic [IW-1:0] idx;
    logic         done;
    logic         tmo;
  } exp_t;

  exp_t exp_q[$];

  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   busy_from = 1;
  int   busy_to   = 0;

  logic lst_en    = 1'b0;
  logic lst_ack   = 1'b0;
  logic stray_ack = 1'b0;
  int   ack_delay = 0;
  int   ack_hold  = 1;
  int   ack_at    = -1;

  assign ack_i = lst_ack | stray_ack;

  always @(posedge clk) cyc = cyc + 1;

  // Listener: acks ack_delay cycles after each strobe it sees, holding ack_hold cycles.
  always @(negedge clk) begin
    if (lst_en && (evt_o != '0)) ack_at = cyc + ack_delay;
    lst_ack = (ack_at >= 0) && (cyc >= ack_at) && (cyc < ack_at + ack_hold);
  end

  // Monitor: busy window every cycle; every strobe/done pulse popped from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (rst_n) begin
      exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      checks++;
      if (busy_o !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy_o, exp_busy);
      end
      if ((evt_o !== '0) || (done_o !== 1'b0)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d evt=%b done=%b", cyc, evt_o, done_o);
        end else begin
          e = exp_q.pop_front();
          if ((e.cyc != cyc) || (e.evt !== evt_o) || (e.done !== done_o) ||
              (e.tmo !== timeout_o) || ((e.evt != '0) && (e.idx !== evt_idx_o))) begin
            errors++;
            $display("FAIL output got cyc=%0d evt=%b idx=%0d done=%b to=%b expected cyc=%0d evt=%b idx=%0d done=%b to=%b",
                     cyc, evt_o, evt_idx_o, done_o, timeout_o,
                     e.cyc, e.evt, e.idx, e.done, e.tmo);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_evt"},  32'(evt_o), 32'd0);
    chk({name, "_idx"},  32'(evt_idx_o), 32'd0);
    chk({name, "_busy"}, 32'(busy_o), 32'd0);
    chk({name, "_done"}, 32'(done_o), 32'd0);
    chk({name, "_to"},   32'(timeout_o), 32'd0);
  endtask

  // Reference model. Start sampled in cycle s; strobe k sits gap+2 cycles after the start
  // cycle or after the previous ack cycle; the ack comes d cycles into the strobe; done
  // follows the last ack. With tmo_run, no ack arrives and the timeout ends the run.
  task automatic model(input int s, input int n, input int g, input int d, input bit tmo_run);
    exp_t e;
    logic [N-1:0] one;
    int t;
    int a;
    one = 1;
    if (n == 0) begin
      e.cyc = s + 1; e.evt = '0; e.idx = '0; e.done = 1'b1; e.tmo = 1'b0;
      exp_q.push_back(e);
      busy_from = 1; busy_to = 0;
      return;
    end
    t = s + g + 2;
    a = t;
    for (int k = 0; k < (tmo_run ? 1 : n); k++) begin
      e.cyc = t; e.evt = one << (k % N); e.idx = IW'(k % N); e.done = 1'b0; e.tmo = 1'b0;
      exp_q.push_back(e);
      a = t + (tmo_run ? TMO : d);
      t = a + g + 2;
    end
    e.cyc = a + 1; e.evt = '0; e.idx = '0; e.done = 1'b1; e.tmo = tmo_run;
    exp_q.push_back(e);
    busy_from = s + 1;
    busy_to   = a;
  endtask

  task automatic start_run(input int n, input int g, input int d, input bit tmo_run,
                           output int s);
    @(posedge clk); #1;
    ack_delay = d;
    start_i   = 1'b1;
    count_i   = CNT_W'(n);
    gap_i     = GAP_W'(g);
    s         = cyc;
    model(s, n, g, d, tmo_run);
    @(posedge clk); #1;
    start_i = 1'b0;
    count_i = CNT_W'($urandom);
    gap_i   = GAP_W'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0) && (k < 600)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected outputs never appeared", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    int g;
    int d;

    rst_n   = 1'b1;
    start_i = 1'b0;
    count_i = '0;
    gap_i   = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // count=3, gap=1, ack one cycle after each strobe.
    lst_en = 1'b1; ack_hold = 1;
    start_run(3, 1, 1, 1'b0, s);
    wait_drain("t1");

    // count=5, gap=0, ack in the strobe cycle: strobes two cycles apart, wrap after C.
    start_run(5, 0, 0, 1'b0, s);
    wait_drain("t2");

    // count=0: immediate done, no strobe, never busy.
    start_run(0, 4, 0, 1'b0, s);
    wait_drain("t3");

    // Second start mid-run is ignored; ack held two cycles counts once.
    ack_hold = 2;
    start_run(2, 2, 1, 1'b0, s);
    @(posedge clk); #1;
    start_i = 1'b1; count_i = CNT_W'(9); gap_i = GAP_W'(0);
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_drain("t4");

    // Randomized runs, with stray acks while idle.
    for (int r = 0; r < 14; r++) begin
      n = $urandom_range(0, 7);
      g = $urandom_range(0, 5);
      d = $urandom_range(0, 3);
      ack_hold = $urandom_range(1, 2);
      start_run(n, g, d, 1'b0, s);
      wait_drain("rand");
      stray_ack = 1'b1;
      @(posedge clk); #1;
      stray_ack = 1'b0;
      @(posedge clk);
    end

`ifdef EVT_TIMEOUT_EN
    // No ack: timeout after TIMEOUT wait cycles, then a clean start clears it.
    lst_en = 1'b0;
    start_run(2, 1, 0, 1'b1, s);
    wait_drain("t5_timeout");
    #1 chk("t5_sticky", 32'(timeout_o), 32'd1);
    lst_en = 1'b1; ack_hold = 1;
    start_run(1, 0, 1, 1'b0, s);
    wait_drain("t5_restart");
    #1 chk("t5_cleared", 32'(timeout_o), 32'd0);
`else
    #1 chk("to_tied", 32'(timeout_o), 32'd0);
`endif

    // Async reset while waiting for ack: outputs drop before the next edge, no done.
    lst_en = 1'b0;
    start_run(3, 2, 0, 1'b0, s);
    while (cyc < s + 6) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    busy_from = 1; busy_to = 0;
    #1 chk_all_zero("t6_async");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("t6_idle");
    lst_en = 1'b1; ack_hold = 1;
    start_run(1, 0, 1, 1'b0, s);
    wait_drain("t6_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_event_trigger_seq
